float_point_mult_requester: RTL and testbench

- Initiator side of the float-multiplier handshake.
- Buffers operand pairs from an upstream producer in a small FIFO.
- Issues each pair to a float_point_multiplier_wrapper-style responder using a one-cycle data-ready pulse, then waits for the product-ready pulse.
- Captures each product into a single-entry output register with a valid/ready interface.

---
 rtl/float_point_mult_requester.sv | 202 ++++++++++++++++++++
 tb/tb_float_point_mult_requester.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/float_point_mult_requester.sv
// ---------------------------------------------------------------------------
// float_point_mult_requester
//
// Initiator side of the float-multiplier handshake. Operand pairs from an
// upstream producer are buffered in a small in-order FIFO. Each pair is
// issued to the multiplier with a one-cycle mult_data_ready pulse. The block
// then waits for the mult_product_ready pulse and captures the product into a
// single-entry output register with a valid/ready interface. A new pair is
// only issued while the output register is empty, so at most one product is
// ever in flight or held.
//
// Parameters:
//   EXP_LEN        exponent width
//   MANTISSA_LEN   mantissa width; word width W = EXP_LEN+MANTISSA_LEN+1
//   FIFO_DEPTH     operand-pair FIFO entries (power of two, >= 2)
//   TIMEOUT_CYCLES WAIT-state watchdog limit (only with the watchdog)
//
// Optional feature (compile-time macro FP_MULT_REQ_TIMEOUT_EN):
//   When defined, a watchdog abandons a multiply after TIMEOUT_CYCLES WAIT
//   cycles without a product and sets the sticky timeout_err flag. When
//   undefined, WAIT waits indefinitely and timeout_err is tied low.
//
// Ports:
//   clock               rising-edge clock
//   reset_n             asynchronous active-low reset
//   in_a, in_b          operand pair from upstream
//   in_valid/in_ready   upstream handshake (in_ready = FIFO not full)
//   mult_inp_a/b        operands to the multiplier, stable until capture
//   mult_data_ready     one-cycle issue pulse
//   mult_product_ready  multiplier result-valid pulse
//   mult_product        multiplier result
//   out_product         captured product
//   out_valid/out_ready downstream handshake
//   busy                high when not IDLE or FIFO non-empty
//   timeout_err         sticky watchdog error flag
// ---------------------------------------------------------------------------
module float_point_mult_requester #(
    parameter int EXP_LEN        = 8,
    parameter int MANTISSA_LEN   = 23,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [EXP_LEN+MANTISSA_LEN:0] in_a,
    input  logic [EXP_LEN+MANTISSA_LEN:0] in_b,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [EXP_LEN+MANTISSA_LEN:0] mult_inp_a,
    output logic [EXP_LEN+MANTISSA_LEN:0] mult_inp_b,
    output logic                          mult_data_ready,
    input  logic                          mult_product_ready,
    input  logic [EXP_LEN+MANTISSA_LEN:0] mult_product,
    output logic [EXP_LEN+MANTISSA_LEN:0] out_product,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          busy,
    output logic                          timeout_err
);

    localparam int W     = EXP_LEN + MANTISSA_LEN + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [W-1:0]     fifo_a [FIFO_DEPTH];
    logic [W-1:0]     fifo_b [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;

    logic push, pop, capture, to_fire;

    assign in_ready = (count < DEPTH_CNT);
    assign push     = in_valid && in_ready;
    assign busy     = (state != ST_IDLE) || (count != '0);

    // Storage needs no reset: an entry is only read once count says it holds
    // a pushed pair.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_a[wr_ptr] <= in_a;
            fifo_b[wr_ptr] <= in_b;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (pop) state_next = ST_ISSUE;
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT:  if (capture || to_fire) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Output / control decode. A product pulse outside WAIT is ignored, which
    // covers both ISSUE and a stale pulse arriving after a reset.
    always_comb begin
        mult_data_ready = 1'b0;
        pop             = 1'b0;
        capture         = 1'b0;
        case (state)
            ST_IDLE:  pop             = (count != '0) && !out_valid;
            ST_ISSUE: mult_data_ready = 1'b1;
            ST_WAIT:  capture         = mult_product_ready;
            default:  ;
        endcase
    end

    // Operands are loaded on pop and held until the next pop, so they stay
    // stable from ISSUE through capture.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mult_inp_a <= '0;
            mult_inp_b <= '0;
        end else if (pop) begin
            mult_inp_a <= fifo_a[rd_ptr];
            mult_inp_b <= fifo_b[rd_ptr];
        end
    end

    // Capture cannot coincide with a downstream accept: issuing requires
    // out_valid low, and it stays low until this capture.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_product <= '0;
            out_valid   <= 1'b0;
        end else if (capture) begin
            out_product <= mult_product;
            out_valid   <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid   <= 1'b0;
        end
    end

`ifdef FP_MULT_REQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] wait_cnt;
    logic            timeout_q;

    // wait_cnt holds the number of WAIT cycles already elapsed, so the limit
    // is hit in the TIMEOUT_CYCLES-th WAIT cycle. A product in that same
    // cycle takes priority over the timeout.
    assign to_fire = (state == ST_WAIT) && !mult_product_ready && (wait_cnt == TO_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state == ST_ISSUE)
                wait_cnt <= '0;
            else if (state == ST_WAIT)
                wait_cnt <= wait_cnt + 1'b1;
            if (to_fire)
                timeout_q <= 1'b1;
        end
    end

    assign timeout_err = timeout_q;
`else
    logic unused_timeout_cfg;

    assign to_fire            = 1'b0;
    assign timeout_err        = 1'b0;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

endmodule

// File: tb/tb_float_point_mult_requester.sv
module tb_float_point_mult_requester;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_p;
    } vec_t;

    logic         clock   = 1'b0;
    logic         reset_n = 1'b1;
    logic [W-1:0] in_a    = '0;
    logic [W-1:0] in_b    = '0;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b0;
    logic         in_ready;
    logic [W-1:0] mult_inp_a, mult_inp_b;
    logic         mult_data_ready;
    logic         mult_product_ready;
    logic [W-1:0] mult_product;
    logic [W-1:0] out_product;
    logic         out_valid;
    logic         busy;
    logic         timeout_err;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    float_point_mult_requester dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .in_a               (in_a),
        .in_b               (in_b),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .mult_inp_a         (mult_inp_a),
        .mult_inp_b         (mult_inp_b),
        .mult_data_ready    (mult_data_ready),
        .mult_product_ready (mult_product_ready),
        .mult_product       (mult_product),
        .out_product        (out_product),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .busy               (busy),
        .timeout_err        (timeout_err)
    );

    // Reference single-precision multiply for normal numbers (truncating);
    // the operands used here all give exact products.
    function automatic logic [W-1:0] fmul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [47:0] p;
        logic [9:0]  e;
        logic [22:0] m;
        if (a[30:0] == 31'd0 || b[30:0] == 31'd0)
            return {a[31] ^ b[31], 31'd0};
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
        if (p[47]) begin
            m = p[46:24];
            e = e + 10'd1;
        end else begin
            m = p[45:23];
        end
        return {a[31] ^ b[31], e[7:0], m};
    endfunction

    // Responder model: fixed latency, can be stalled, forgets on reset.
    logic         resp_stall  = 1'b0;
    int           resp_lat    = 4;
    logic         pend        = 1'b0;
    int           cd          = 0;
    logic         model_ready = 1'b0;
    logic [W-1:0] model_prod  = '0;
    logic         force_ready = 1'b0;
    logic [W-1:0] force_prod  = '0;

    assign mult_product_ready = model_ready | force_ready;
    assign mult_product       = force_ready ? force_prod : model_prod;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend        <= 1'b0;
            cd          <= 0;
            model_ready <= 1'b0;
        end else begin
            model_ready <= 1'b0;
            if (mult_data_ready) begin
                pend       <= 1'b1;
                cd         <= resp_lat;
                model_prod <= fmul(mult_inp_a, mult_inp_b);
            end else if (pend && !resp_stall) begin
                if (cd <= 1) begin
                    model_ready <= 1'b1;
                    pend        <= 1'b0;
                end else begin
                    cd <= cd - 1;
                end
            end
        end
    end

    // Monitor: accepted products in order, issue count, pulse width.
    logic [W-1:0] got_q[$];
    int issue_cnt = 0;
    int run_len   = 0;
    int max_run   = 0;

    always @(posedge clock) begin
        if (out_valid && out_ready) got_q.push_back(out_product);
        if (mult_data_ready) begin
            issue_cnt <= issue_cnt + 1;
            run_len   <= run_len + 1;
            if (run_len + 1 > max_run) max_run <= run_len + 1;
        end else begin
            run_len <= 0;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
        int waited = 0;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        while (!in_ready && waited < 200) begin
            tick();
            waited++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL push_wait: in_ready %b expected 1 within 200 cycles", in_ready);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic waitOut(input string name, input int n, input int budget);
        int k = 0;
        while (got_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        checkOutput(name, W'(got_q.size()), W'(n));
    endtask

    task automatic waitValid(input string name, input int budget);
        int k = 0;
        while (!out_valid && k < budget) begin
            tick();
            k++;
        end
        checkBit(name, out_valid, 1'b1);
    endtask

    task automatic waitIssue(input string name, input int budget);
        int k = 0;
        while (!mult_data_ready && k < budget) begin
            tick();
            k++;
        end
        checkBit(name, mult_data_ready, 1'b1);
    endtask

    task automatic waitIdle(input string name, input int budget);
        int k = 0;
        while (busy && k < budget) begin
            tick();
            k++;
        end
        checkBit(name, busy, 1'b0);
    endtask

    vec_t fill_v [5];
    vec_t wrap_v [9];

    initial begin
        int i0;
        int n;

        fill_v[0] = '{32'h3F800000, 32'h40000000, 32'h40000000};
        fill_v[1] = '{32'h40000000, 32'h40000000, 32'h40800000};
        fill_v[2] = '{32'h40400000, 32'h40000000, 32'h40C00000};
        fill_v[3] = '{32'h40800000, 32'h40000000, 32'h41000000};
        fill_v[4] = '{32'h40A00000, 32'h40000000, 32'h41200000};

        wrap_v[0] = '{32'hC0000000, 32'h40400000, 32'hC0C00000};
        wrap_v[1] = '{32'h3F000000, 32'h40800000, 32'h40000000};
        wrap_v[2] = '{32'h3FC00000, 32'h3FC00000, 32'h40100000};
        wrap_v[3] = '{32'h40200000, 32'h40800000, 32'h41200000};
        wrap_v[4] = '{32'h3E800000, 32'h3F000000, 32'h3E000000};
        wrap_v[5] = '{32'h40400000, 32'h40400000, 32'h41100000};
        wrap_v[6] = '{32'hBF800000, 32'hBF800000, 32'h3F800000};
        wrap_v[7] = '{32'h40E00000, 32'h40000000, 32'h41600000};
        wrap_v[8] = '{32'h40C00000, 32'h3FC00000, 32'h41100000};

        // Reset state
        #2 reset_n = 1'b0;
        tick();
        tick();
        checkBit("rst_out_valid", out_valid, 1'b0);
        checkBit("rst_data_ready", mult_data_ready, 1'b0);
        checkOutput("rst_out_product", out_product, 32'h0);
        checkOutput("rst_inp_a", mult_inp_a, 32'h0);
        checkOutput("rst_inp_b", mult_inp_b, 32'h0);
        checkBit("rst_in_ready", in_ready, 1'b1);
        checkBit("rst_busy", busy, 1'b0);
        checkBit("rst_timeout_err", timeout_err, 1'b0);
        reset_n = 1'b1;
        tick();

        // Single op 1.5 * 2.0 with latency checks; product left held
        $display("[TB] single operation");
        i0 = issue_cnt;
        applyStimulus(32'h3FC00000, 32'h40000000);
        checkBit("lat_idle_no_issue", mult_data_ready, 1'b0);
        checkBit("busy_after_push", busy, 1'b1);
        tick();
        checkBit("lat_issue_pulse", mult_data_ready, 1'b1);
        checkOutput("issue_inp_a", mult_inp_a, 32'h3FC00000);
        checkOutput("issue_inp_b", mult_inp_b, 32'h40000000);
        tick();
        checkBit("lat_pulse_end", mult_data_ready, 1'b0);
        waitValid("single_valid", 50);
        checkOutput("single_product", out_product, 32'h40400000);

        // Fill the FIFO behind the held product, hold off a fifth push
        $display("[TB] fifo fill");
        for (int i = 0; i < 4; i++) applyStimulus(fill_v[i].a, fill_v[i].b);
        checkBit("fill_in_ready_low", in_ready, 1'b0);
        checkOutput("fill_issue_count", W'(issue_cnt - i0), 32'd1);
        in_a     = fill_v[4].a;
        in_b     = fill_v[4].b;
        in_valid = 1'b1;
        repeat (3) tick();
        checkBit("fifth_held", in_ready, 1'b0);
        checkOutput("held_product", out_product, 32'h40400000);
        out_ready = 1'b1;
        applyStimulus(fill_v[4].a, fill_v[4].b);
        waitOut("fill_out_count", 6, 300);
        n = (got_q.size() < 6) ? got_q.size() : 6;
        if (n > 0) checkOutput("fill_prod_first", got_q[0], 32'h40400000);
        for (int i = 1; i < n; i++) checkOutput($sformatf("fill_prod_%0d", i), got_q[i], fill_v[i-1].exp_p);
        waitIdle("fill_busy_low", 100);

        // Output backpressure with two pairs queued
        $display("[TB] output backpressure");
        got_q.delete();
        out_ready = 1'b0;
        i0 = issue_cnt;
        applyStimulus(32'h40200000, 32'h40800000);
        applyStimulus(32'h3E800000, 32'h3F000000);
        waitValid("bp_valid", 50);
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput($sformatf("bp_hold_%0d", i), out_product, 32'h41200000);
        end
        checkBit("bp_still_valid", out_valid, 1'b1);
        checkOutput("bp_issue_count", W'(issue_cnt - i0), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkBit("bp_cleared", out_valid, 1'b0);
        checkBit("bp_no_issue_yet", mult_data_ready, 1'b0);
        tick();
        checkBit("bp_second_issue", mult_data_ready, 1'b1);
        out_ready = 1'b1;
        waitOut("bp_out_count", 2, 100);
        if (got_q.size() >= 2) begin
            checkOutput("bp_prod_0", got_q[0], 32'h41200000);
            checkOutput("bp_prod_1", got_q[1], 32'h3E000000);
        end

        // Reset while waiting, then a stale product pulse
        $display("[TB] reset mid-wait");
        got_q.delete();
        resp_stall = 1'b1;
        applyStimulus(32'h40400000, 32'h40400000);
        waitIssue("rst_wait_issue", 20);
        tick();
        tick();
        checkBit("rst_wait_busy", busy, 1'b1);
        reset_n = 1'b0;
        #1;
        checkBit("rst_async_busy", busy, 1'b0);
        checkOutput("rst_async_inp_a", mult_inp_a, 32'h0);
        tick();
        reset_n    = 1'b1;
        resp_stall = 1'b0;
        tick();
        i0 = issue_cnt;
        force_prod  = 32'h41100000;
        force_ready = 1'b1;
        tick();
        force_ready = 1'b0;
        tick();
        tick();
        checkBit("stale_out_valid", out_valid, 1'b0);
        checkBit("stale_data_ready", mult_data_ready, 1'b0);
        checkBit("stale_busy", busy, 1'b0);
        checkBit("stale_in_ready", in_ready, 1'b1);
        checkOutput("stale_no_issue", W'(issue_cnt - i0), 32'd0);
        checkOutput("stale_no_output", W'(got_q.size()), 32'd0);

        // Nine pairs through a depth-4 FIFO: pointers wrap twice
        $display("[TB] fifo wrap");
        got_q.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) applyStimulus(wrap_v[i].a, wrap_v[i].b);
        waitOut("wrap_out_count", 9, 500);
        n = (got_q.size() < 9) ? got_q.size() : 9;
        for (int i = 0; i < n; i++) checkOutput($sformatf("wrap_prod_%0d", i), got_q[i], wrap_v[i].exp_p);
        waitIdle("wrap_busy_low", 100);

`ifdef FP_MULT_REQ_TIMEOUT_EN
        // Silent multiplier: 16 WAIT cycles, then flag and move on
        $display("[TB] watchdog");
        got_q.delete();
        resp_stall = 1'b1;
        applyStimulus(32'h40E00000, 32'h40000000);
        applyStimulus(32'h40C00000, 32'h3FC00000);
        waitIssue("to_first_issue", 20);
        repeat (16) tick();
        checkBit("to_not_yet", timeout_err, 1'b0);
        tick();
        checkBit("to_flag", timeout_err, 1'b1);
        checkBit("to_no_valid", out_valid, 1'b0);
        tick();
        checkBit("to_next_issue", mult_data_ready, 1'b1);
        checkOutput("to_next_inp_a", mult_inp_a, 32'h40C00000);
        resp_stall = 1'b0;
        waitOut("to_out_count", 1, 100);
        if (got_q.size() >= 1) checkOutput("to_prod", got_q[0], 32'h41100000);
        checkBit("to_sticky", timeout_err, 1'b1);
`else
        checkBit("no_watchdog_flag", timeout_err, 1'b0);
`endif

        checkOutput("pulse_width", W'(max_run), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
